// File: rtl/hilo_mul_issue.sv
// Multiply issue/commit controller: launches MULT/MULTU to a multi-cycle multiplier, stalls EX
// while the product is in flight, and owns the HI/LO registers. Watchdog macro: HILO_MUL_WATCHDOG_EN.
module hilo_mul_issue #(
    parameter int unsigned TIMEOUT = 32'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_mult,
    input  logic        op_signed,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        pipe_enable,
    input  logic        flush,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_annul,
    input  logic [63:0] mul_result,
    input  logic        mul_ready,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic        signed_q, signed_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        annul_q, annul_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mult_req_s;
    logic        wr_ok_s;
    logic        wd_expire_s;

    assign mult_req_s = op_valid & op_mult & ~flush;
    assign wr_ok_s    = op_valid & pipe_enable & ~flush;

`ifdef HILO_MUL_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign wd_expire_s = (cnt_q == CNT_W'(TIMEOUT - 32'd1));

    // Watchdog counter and sticky timeout flag; counter restarts on every BUSY entry.
    always_comb begin
        cnt_d     = {CNT_W{1'b0}};
        timeout_d = timeout_q;
        if (state_q == S_BUSY && state_d == S_BUSY) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        if (state_q == S_BUSY && !flush && !mul_ready && wd_expire_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mul_timeout = timeout_q;
`else
    assign wd_expire_s = 1'b0;
    assign mul_timeout = 1'b0;
`endif

    // Next-state, operand capture and HI/LO update.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        signed_d = signed_q;
        a_d      = a_q;
        b_d      = b_q;
        annul_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mult_req_s) begin
                    a_d      = rs_data;
                    b_d      = rt_data;
                    signed_d = op_signed;
                    start_d  = 1'b1;
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
                if (wr_ok_s && op_mthi) begin
                    hi_d = rs_data;
                end else begin
                    hi_d = hi_q;
                end
                if (wr_ok_s && op_mtlo) begin
                    lo_d = rs_data;
                end else begin
                    lo_d = lo_q;
                end
            end
            S_BUSY: begin
                // A flush beats a same-cycle ready: the product is dropped.
                if (flush) begin
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end else if (mul_ready) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    start_d = 1'b0;
                    state_d = pipe_enable ? S_IDLE : S_HOLD;
                end else if (wd_expire_s) begin
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_HOLD: begin
                if (flush || pipe_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // Main state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            annul_q  <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            annul_q  <= annul_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign stall = rst & (((state_q == S_IDLE) & mult_req_s) |
                          ((state_q == S_BUSY) & ~mul_ready));

    assign mul_start  = start_q;
    assign mul_signed = signed_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_annul  = annul_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule
